// File: rtl/sysid_ext.sv
// System ID / uptime slave on Avalon-MM: ID, build stamp, 64-bit
// uptime counter with latched high word, control and scratch regs.
module sysid_ext #(
  parameter logic [31:0] ID_VALUE    = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP   = 32'h5E73_4A36,
  parameter int          NUM_SCRATCH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam logic [2:0] SCR_LAST = 3'(NUM_SCRATCH - 1);

  logic [63:0] cnt;
  logic [31:0] hi_snap;
  logic        en;
  logic [31:0] scratch [8];

  logic [2:0]  scr_idx;
  logic        scr_hit;
  logic        ctrl_wr;
  logic        clr;
  logic [31:0] rd_mux;

  assign scr_idx = address[2:0];
  assign scr_hit = address[3] && (scr_idx <= SCR_LAST);
  assign ctrl_wr = write && (address == 4'd4) && byteenable[0];
  assign clr     = ctrl_wr && writedata[1];

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      address == 4'd0: rd_mux = ID_VALUE;
      address == 4'd1: rd_mux = TIMESTAMP;
      address == 4'd2: rd_mux = cnt[31:0];
      address == 4'd3: rd_mux = hi_snap;
      address == 4'd4: rd_mux = {31'd0, en};
      scr_hit:         rd_mux = scratch[scr_idx];
      default:         rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
      hi_snap       <= '0;
    end else begin
      readdatavalid <= read;
      if (read)
        readdata <= rd_mux;
      // LO read freezes the matching high word for a later HI read
      if (read && address == 4'd2)
        hi_snap <= cnt[63:32];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      en  <= 1'b1;
    end else begin
      if (clr)
        cnt <= '0;
      else if (en)
        cnt <= cnt + 64'd1;
      if (ctrl_wr)
        en <= writedata[0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++)
        scratch[i] <= '0;
    end else if (write && scr_hit) begin
      for (int i = 0; i < 8; i++)
        if (scr_idx == 3'(i))
          for (int b = 0; b < 4; b++)
            if (byteenable[b])
              scratch[i][8*b +: 8] <= writedata[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_sysid_ext.sv
// Bench for sysid_ext: vector table, corner sequences and random
// traffic checked against a register-map model.
module tb_sysid_ext;

  localparam logic [31:0] TS = 32'h5E73_4A36;
  localparam int          NS = 2;

  logic        clock;
  logic        reset_n;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  sysid_ext #(
    .ID_VALUE(32'h0000_0000),
    .TIMESTAMP(TS),
    .NUM_SCRATCH(NS)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .address(address),
    .read(read),
    .write(write),
    .writedata(writedata),
    .byteenable(byteenable),
    .readdata(readdata),
    .readdatavalid(readdatavalid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // model state: uptime as a plain number, register file as arrays
  logic [63:0] m_up;
  logic [31:0] m_hi;
  logic        m_en;
  logic [31:0] m_scr [8];
  logic [31:0] m_rd;
  logic        m_rdv;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [3:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] exp;
    logic        exp_v;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(
    input logic rd, input logic wr, input logic [3:0] a,
    input logic [31:0] d, input logic [3:0] be,
    input logic [31:0] exp, input logic exp_v);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.d = d; v.be = be;
    v.exp = exp; v.exp_v = exp_v;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_up = '0; m_hi = '0; m_en = 1'b1;
    m_rd = '0; m_rdv = 1'b0;
    for (int i = 0; i < 8; i++) m_scr[i] = '0;
  endtask

  function automatic logic [31:0] m_peek(input logic [3:0] a);
    int ia = int'(a);
    if (ia == 0) return 32'h0;
    if (ia == 1) return TS;
    if (ia == 2) return m_up[31:0];
    if (ia == 3) return m_hi;
    if (ia == 4) return {31'd0, m_en};
    if (ia >= 8 && ia - 8 < NS) return m_scr[ia-8];
    return 32'h0;
  endfunction

  task automatic m_edge(input logic r, input logic w,
                        input logic [3:0] a, input logic [31:0] d,
                        input logic [3:0] be);
    int ia = int'(a);
    logic ctl = w && ia == 4 && be[0];
    m_rdv = r;
    if (r) begin
      m_rd = m_peek(a);
      if (ia == 2) m_hi = m_up[63:32];
    end
    if (ctl && d[1]) m_up = '0;
    else if (m_en) m_up = m_up + 64'd1;
    if (ctl) m_en = d[0];
    if (w && ia >= 8 && ia - 8 < NS)
      for (int k = 0; k < 4; k++)
        if (be[k]) m_scr[ia-8][8*k +: 8] = d[8*k +: 8];
  endtask

  task automatic bus(input logic r, input logic w,
                     input logic [3:0] a, input logic [31:0] d,
                     input logic [3:0] be);
    read = r; write = w; address = a;
    writedata = d; byteenable = be;
    @(posedge clock);
    m_edge(r, w, a, d, be);
    #1;
    read = 1'b0; write = 1'b0;
    chk("model_rdata", readdata, m_rd);
    chk("model_rvalid", {31'd0, readdatavalid}, {31'd0, m_rdv});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
  endtask

  initial begin
    reset_n = 1'b1;
    read = 1'b0; write = 1'b0; address = '0;
    writedata = '0; byteenable = '0;
    m_reset();
    #1 reset_n = 1'b0;
    #1;
    chk("reset_rdata", readdata, 32'h0);
    chk("reset_rvalid", {31'd0, readdatavalid}, 32'd0);
    @(posedge clock);
    #3 reset_n = 1'b1;

    // counter leaves reset at 0 and is 1 after the first edge
    bus(1'b1, 1'b0, 4'd2, 32'd0, 4'd0);
    chk("up_first_edge", readdata, 32'd0);
    bus(1'b1, 1'b0, 4'd2, 32'd0, 4'd0);
    chk("up_second_edge", readdata, 32'd1);

    tbl[0]  = mk(1, 0, 4'd0,  32'h0,        4'h0, 32'h0,        1);
    tbl[1]  = mk(1, 0, 4'd1,  32'h0,        4'h0, TS,           1);
    tbl[2]  = mk(0, 0, 4'd0,  32'h0,        4'h0, TS,           0);
    tbl[3]  = mk(0, 1, 4'd8,  32'hFFFFFFFF, 4'hF, TS,           0);
    tbl[4]  = mk(0, 1, 4'd8,  32'h12345678, 4'h5, TS,           0);
    tbl[5]  = mk(1, 0, 4'd8,  32'h0,        4'h0, 32'hFF34FF78, 1);
    tbl[6]  = mk(0, 1, 4'd15, 32'hDEADBEEF, 4'hF, 32'hFF34FF78, 0);
    tbl[7]  = mk(1, 0, 4'd15, 32'h0,        4'h0, 32'h0,        1);
    tbl[8]  = mk(0, 1, 4'd0,  32'hAAAA5555, 4'hF, 32'h0,        0);
    tbl[9]  = mk(1, 0, 4'd0,  32'h0,        4'h0, 32'h0,        1);
    tbl[10] = mk(0, 1, 4'd9,  32'h0000000A, 4'hF, 32'h0,        0);
    tbl[11] = mk(1, 1, 4'd9,  32'h0000000B, 4'hF, 32'hA,        1);
    tbl[12] = mk(1, 0, 4'd9,  32'h0,        4'h0, 32'hB,        1);
    tbl[13] = mk(0, 1, 4'd4,  32'h00000000, 4'hE, 32'hB,        0);
    tbl[14] = mk(1, 0, 4'd4,  32'h0,        4'h0, 32'h1,        1);
    tbl[15] = mk(1, 0, 4'd10, 32'h0,        4'h0, 32'h0,        1);
    tbl[16] = mk(0, 1, 4'd3,  32'hFFFFFFFF, 4'hF, 32'h0,        0);
    tbl[17] = mk(1, 0, 4'd3,  32'h0,        4'h0, 32'h0,        1);

    foreach (tbl[i]) begin
      bus(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].be);
      chk($sformatf("vec%0d_rdata", i), readdata, tbl[i].exp);
      chk($sformatf("vec%0d_rvalid", i),
          {31'd0, readdatavalid}, {31'd0, tbl[i].exp_v});
    end

    // CLR: counter restarts from 0, EN survives
    bus(1'b0, 1'b1, 4'd4, 32'h3, 4'h1);
    idle(3);
    bus(1'b1, 1'b0, 4'd2, 32'd0, 4'd0);
    chk("clr_lo", readdata, 32'd3);
    bus(1'b1, 1'b0, 4'd4, 32'd0, 4'd0);
    chk("clr_ctrl", readdata, 32'd1);

    // low-word carry into high word, snapshot via LO read
    bus(1'b0, 1'b1, 4'd4, 32'h0, 4'h1);
    force dut.cnt = 64'h0000_0000_FFFF_FFFF;
    #1 release dut.cnt;
    m_up = 64'h0000_0000_FFFF_FFFF;
    bus(1'b0, 1'b1, 4'd4, 32'h1, 4'h1);
    idle(1);
    bus(1'b1, 1'b0, 4'd2, 32'd0, 4'd0);
    chk("carry_lo", readdata, 32'h0);
    idle(5);
    bus(1'b1, 1'b0, 4'd3, 32'd0, 4'd0);
    chk("carry_hi_snap", readdata, 32'h1);

    // full 64-bit wrap to zero
    bus(1'b0, 1'b1, 4'd4, 32'h0, 4'h1);
    force dut.cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.cnt;
    m_up = 64'hFFFF_FFFF_FFFF_FFFF;
    bus(1'b0, 1'b1, 4'd4, 32'h1, 4'h1);
    bus(1'b1, 1'b0, 4'd2, 32'd0, 4'd0);
    chk("wrap_pre_lo", readdata, 32'hFFFFFFFF);
    bus(1'b1, 1'b0, 4'd2, 32'd0, 4'd0);
    chk("wrap_lo", readdata, 32'h0);
    bus(1'b1, 1'b0, 4'd3, 32'd0, 4'd0);
    chk("wrap_hi", readdata, 32'h0);

    for (int i = 0; i < 600; i++) begin
      logic r, w;
      logic [3:0] a, be;
      r  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 15));
      be = 4'($urandom_range(0, 15));
      bus(r, w, a, $urandom, be);
    end

    // async reset while a read result is on the bus
    bus(1'b0, 1'b1, 4'd8, 32'hCAFE0001, 4'hF);
    bus(1'b0, 1'b1, 4'd4, 32'h0, 4'h1);
    read = 1'b1; address = 4'd1;
    @(posedge clock);
    #1 read = 1'b0;
    chk("pre_rst_rvalid", {31'd0, readdatavalid}, 32'd1);
    chk("pre_rst_rdata", readdata, TS);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_rdata", readdata, 32'h0);
    chk("mid_rst_rvalid", {31'd0, readdatavalid}, 32'd0);
    @(posedge clock);
    #3 reset_n = 1'b1;
    m_reset();
    bus(1'b1, 1'b0, 4'd2, 32'd0, 4'd0);
    chk("post_rst_up0", readdata, 32'd0);
    bus(1'b1, 1'b0, 4'd2, 32'd0, 4'd0);
    chk("post_rst_up1", readdata, 32'd1);
    bus(1'b1, 1'b0, 4'd8, 32'd0, 4'd0);
    chk("post_rst_scr", readdata, 32'd0);
    bus(1'b1, 1'b0, 4'd4, 32'd0, 4'd0);
    chk("post_rst_ctrl", readdata, 32'd1);
    idle(1);
    chk("post_rst_idle_v", {31'd0, readdatavalid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
